// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : aes_pkg                                                      |
// | Description : Shared constants, FSM state type and AES byte/column        |
// |               transforms used by the iterative round sequencer.           |
// |               Bytes are numbered from the MSB: byte 0 = bits [127:120],    |
// |               byte k sits at row k%4, column k/4 of the AES state.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int BLOCK_W  = 128;
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int NR_FOR_NK(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, with 0 -> 0) followed by
  // the affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Row r of column c takes the byte from column (c+r)%4.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_final_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_final_round                                              |
// | Description : Last AES round: SubBytes, ShiftRows, AddRoundKey (no        |
// |               MixColumns). Purely combinational.                          |
// | Ports       : state_i [127:0] in  - current state                         |
// |               rk_i    [127:0] in  - final round key                        |
// |               state_o [127:0] out - round result                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_final_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rk_i,
  output logic [BLOCK_W-1:0] state_o
);

  assign state_o = shift_rows(sub_bytes(state_i)) ^ rk_i;

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_round_sequencer                                          |
// | Description : Iterative AES encryption controller. One shared full-round  |
// |               datapath runs once per cycle for rounds 1..NR-1, then the   |
// |               final round. Round keys come from an external store,        |
// |               addressed by rk_idx_o and returned combinationally on rk_i. |
// | Ports       : clk, rst (sync, active high)                                 |
// |               in_valid_i / in_ready_o / in_data_i   - plaintext handshake  |
// |               rk_idx_o / rk_i                       - round-key fetch      |
// |               abort_i                               - drop current block   |
// |               busy_o                                - ROUND/FINAL active   |
// |               out_valid_o / out_ready_i / out_data_o - ciphertext handshake|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [BLOCK_W-1:0]  in_data_i,
  output logic [RK_IDX_W-1:0] rk_idx_o,
  input  logic [BLOCK_W-1:0]  rk_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [BLOCK_W-1:0]  out_data_o
);

  if ((NK != 4 && NK != 6 && NK != 8) || NR != NR_FOR_NK(NK)) begin : g_bad_params
    $error("aes_round_sequencer: NK must be 4/6/8 and NR must equal NK+6");
  end

  state_e                fsm_q, fsm_d;
  logic [RK_IDX_W-1:0]   rnd_q, rnd_d;
  logic [BLOCK_W-1:0]    state_q, state_d;

  logic [BLOCK_W-1:0]    full_w;
  logic [BLOCK_W-1:0]    final_w;
  logic [BLOCK_W-1:0]    round_w;
  logic                  accept_w;

  assign full_w = mix_columns(shift_rows(sub_bytes(state_q))) ^ rk_i;

  aes_final_round u_final (
    .state_i (state_q),
    .rk_i    (rk_i),
    .state_o (final_w)
  );

  assign round_w    = (fsm_q == FINAL) ? final_w : full_w;
  assign out_data_o = state_q;

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    out_valid_o = 1'b0;
    rk_idx_o    = '0;
    accept_w    = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready_o = 1'b1;
      end
      ROUND: begin
        busy_o   = 1'b1;
        rk_idx_o = rnd_q;
        state_d  = round_w;
        rnd_d    = rnd_q + 4'd1;
        if (rnd_q == RK_IDX_W'(NR - 1)) fsm_d = FINAL;
      end
      FINAL: begin
        busy_o   = 1'b1;
        rk_idx_o = RK_IDX_W'(NR);
        state_d  = round_w;
        fsm_d    = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        // Taking the next block is only possible while the current one leaves,
        // so back-to-back streaming has no bubble. rk_idx_o stays 0 here so the
        // initial AddRoundKey key is already on rk_i.
        in_ready_o  = out_ready_i;
        if (out_ready_i) fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    accept_w = in_valid_i & in_ready_o;
    if (accept_w) begin
      state_d = in_data_i ^ rk_i;
      rnd_d   = 4'd1;
      fsm_d   = ROUND;
    end

    // Abort overrides everything, including a same-cycle accept.
    if (abort_i) begin
      fsm_d   = IDLE;
      rnd_d   = '0;
      state_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire
